sap_exec_unit: RTL and testbench
================================

Name: sap_exec_unit

Overview:
Parametrised SAP execute unit. It holds the accumulator, the B register, an 8-op ALU, a registered flag set and an iterative shift-add multiplier. It sits on the shared W-bus between the controller/sequencer and memory/IO. It drives the bus through an explicit output-enable, so it never writes a shared interface signal directly.

Parameters:
WIDTH, 8, datapath/bus width in bits (≥4).
MUL_EN, 1, 1 = MUL op and sequencer instantiated; 0 = MUL removed.

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
bus_in  in  WIDTH  W-bus value seen by the unit
bus_out  out  WIDTH  value driven onto W-bus
bus_oe  out  1  1 = unit drives W-bus this cycle
la_n  in  1  load accumulator from bus_in, active low
lb_n  in  1  load B from bus_in, active low
ea  in  1  drive accumulator onto bus
eu  in  1  drive ALU result onto bus and latch flags
op  in  3  alu_op_e: ADD, SUB, AND, OR, XOR, SHL, SHR, MUL
start  in  1  launch MUL (sampled only in IDLE)
busy  out  1  multiplier active
done  out  1  one-cycle pulse, product written
acc_out  out  WIDTH  accumulator
acc_hi  out  WIDTH  product high word
b_out  out  WIDTH  B register
flags  out  4  {C,V,N,Z}, registered
bus_conflict  out  1  combinational, ea & eu both asserted

Behaviour:
- Reset: clr_n low forces, immediately and without waiting for a clock edge: acc, acc_hi, b_out and flags to 0; state to IDLE; busy=0; done=0. bus_oe is combinational and is 0 while clr_n is low.
- Register loads: on a posedge with busy=0, la_n=0 loads acc from bus_in, and lb_n=0 loads B from bus_in. Both may load on the same edge. While busy=1, la_n and lb_n are ignored.
- Bus drive (combinational):
  - ea=1: bus_out=acc, bus_oe=1.
  - else eu=1: bus_out=ALU result, bus_oe=1.
  - else bus_oe=0 and bus_out=0.
  - ea and eu together: ea wins and bus_conflict=1.
  - bus_oe=0 whenever busy=1.
- ALU (A=acc, B=b_out, W-bit wraparound):
  - ADD: A+B. C=carry out.
  - SUB: A+~B+1. C=carry out (1 means no borrow).
  - V = signed overflow for ADD/SUB.
  - AND/OR/XOR: C=0, V=0.
  - SHL: A<<1, C=A[W-1]. SHR: logical A>>1, C=A[0]. V=0 for both.
  - N=result[W-1]. Z=(result==0).
  - MUL on eu: result 0, flags unchanged.
- Flags: latched on a posedge with eu=1, ea=0, busy=0 and op≠MUL.
- MUL FSM, states IDLE/RUN/DONE:
  - IDLE→RUN on a posedge with start=1, op=MUL, MUL_EN=1. Captures multiplier=acc and multiplicand=B, clears the partial product, count=WIDTH.
  - RUN: one shift-add step per edge. After the WIDTH-th step, write the low word to acc and the high word to acc_hi, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - busy = (state≠IDLE), high for WIDTH+1 cycles.
  - MUL flags set on the DONE entry edge: Z = (2W product == 0), C = (acc_hi≠0), V=0, N=0.
  - start while busy is ignored; start with op≠MUL is ignored.
  - Result depends only on the operands captured at start, so later bus activity cannot corrupt it.
- MUL_EN=0: start is ignored, busy and done are tied 0, acc_hi is tied 0.
- clr_n asserted during RUN aborts the multiply: no partial write, state returns to IDLE.

Decomposition:
- Shared package sap_pkg receives:
  - alu_op_e (3-bit enum)
  - exec_state_e {IDLE,RUN,DONE}
  - packed struct sap_flags_t {c,v,n,z}
  - flag bit-index constants
- One natural sub-module, sap_mul_seq: the shift-add multiplier plus its FSM, with start/busy/done and a 2W product output. Instantiate it under a generate on MUL_EN.
- The ALU stays an always_comb block in the top level.

Test Plan:
- Reset: clr_n low mid-cycle with acc=0x5A and busy=1 → acc, acc_hi, b_out, flags all 0; busy=0, done=0, bus_oe=0 without a clock edge.
- ADD: acc=0x7F, B=0x01, eu=1 → bus_out=0x80, bus_oe=1; next edge flags C=0 V=1 N=1 Z=0. Also acc=0xFF, B=0x01 → 0x00 with C=1, Z=1.
- SUB: acc=0x05, B=0x05 → 0x00 with C=1, Z=1. acc=0x03, B=0x05 → 0xFE with C=0, N=1.
- Logic and shifts:
  - acc=0xA5, B=0x0F: AND=0x05, OR=0xAF, XOR=0xAA.
  - SHL 0x81 → 0x02 with C=1. SHR 0x81 → 0x40 with C=1.
- MUL:
  - 0x0F×0x11: busy for 9 cycles, done on the 9th, then acc=0xFF, acc_hi=0x00, C=0.
  - 0xFF×0xFF: acc=0x01, acc_hi=0xFE, C=1.
  - la_n pulsed during RUN → ignored, result still correct.
  - clr_n during RUN → abort, acc=0.
- Bus contention: ea=1 and eu=1 with acc=0x33, B=0x01 (ADD) → bus_out=0x33, bus_conflict=1, flags not latched. Any drive request while busy → bus_oe=0.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared types for the SAP execute unit: ALU opcodes, multiplier states and the flag set.
package sap_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } exec_state_e;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } sap_flags_t;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/sap_exec_unit_mul.sv
// Iterative shift-add multiplier: one step per clock, WIDTH steps, then a one-cycle DONE.
module sap_mul_seq
    import sap_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mplier,
    input  logic [WIDTH-1:0]     mcand,
    output logic                 busy,
    output logic                 done,
    output logic                 wr,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    exec_state_e           state, state_nx;
    logic [CW-1:0]         count;
    logic [2*WIDTH-1:0]    pp, pp_step;
    logic [WIDTH-1:0]      mc, addend;
    logic [WIDTH:0]        sum;

    // pp holds {partial high word, remaining multiplier bits}; each step adds and shifts right.
    always_comb begin
        addend  = pp[0] ? mc : '0;
        sum     = {1'b0, pp[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        pp_step = {sum, pp[WIDTH-1:1]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (count == CW'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            count <= '0;
            pp    <= '0;
            mc    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    pp    <= {{WIDTH{1'b0}}, mplier};
                    mc    <= mcand;
                    count <= CW'(WIDTH);
                end
                RUN: begin
                    pp    <= pp_step;
                    count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign wr      = (state == RUN) && (count == CW'(1));
    assign product = pp_step;

endmodule

// File: rtl/sap_exec_unit.sv
// SAP execute unit: accumulator, B register, 8-op ALU, registered flags and optional multiplier,
// driving the shared W-bus through an explicit output enable.
module sap_exec_unit
    import sap_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    input  logic             la_n,
    input  logic             lb_n,
    input  logic             ea,
    input  logic             eu,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] b_out,
    output logic [3:0]       flags,
    output logic             bus_conflict
);

    alu_op_e              opc;
    logic [WIDTH-1:0]     acc_q, acc_hi_q, b_q;
    sap_flags_t           flags_q, alu_fl;
    logic [WIDTH-1:0]     alu_res, b_eff;
    logic [WIDTH:0]       sum;
    logic                 cin;
    logic                 mul_start, mul_busy, mul_done, mul_wr;
    logic [2*WIDTH-1:0]   mul_prod;

    assign opc       = alu_op_e'(op);
    assign mul_start = start && (opc == OP_MUL);

    // SUB reuses the adder as A + ~B + 1, so C=1 means no borrow.
    always_comb begin
        cin      = (opc == OP_SUB);
        b_eff    = cin ? ~b_q : b_q;
        sum      = {1'b0, acc_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        alu_res  = '0;
        alu_fl.c = 1'b0;
        alu_fl.v = 1'b0;
        case (opc)
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_fl.c = sum[WIDTH];
                alu_fl.v = (acc_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_AND: alu_res = acc_q & b_q;
            OP_OR:  alu_res = acc_q | b_q;
            OP_XOR: alu_res = acc_q ^ b_q;
            OP_SHL: begin
                alu_res  = {acc_q[WIDTH-2:0], 1'b0};
                alu_fl.c = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res  = {1'b0, acc_q[WIDTH-1:1]};
                alu_fl.c = acc_q[0];
            end
            default: alu_res = '0;
        endcase
        alu_fl.n = alu_res[WIDTH-1];
        alu_fl.z = (alu_res == '0);
    end

    generate
        if (MUL_EN) begin : g_mul
            sap_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .clr_n   (clr_n),
                .start   (mul_start),
                .mplier  (acc_q),
                .mcand   (b_q),
                .busy    (mul_busy),
                .done    (mul_done),
                .wr      (mul_wr),
                .product (mul_prod)
            );
        end else begin : g_no_mul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign mul_wr   = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc_q    <= '0;
            acc_hi_q <= '0;
            b_q      <= '0;
            flags_q  <= '0;
        end else if (mul_wr) begin
            acc_q    <= mul_prod[WIDTH-1:0];
            acc_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
            flags_q  <= '{c: (mul_prod[2*WIDTH-1:WIDTH] != '0), v: 1'b0, n: 1'b0,
                          z: (mul_prod == '0)};
        end else if (!mul_busy) begin
            if (!la_n) acc_q <= bus_in;
            if (!lb_n) b_q   <= bus_in;
            if (eu && !ea && (opc != OP_MUL)) flags_q <= alu_fl;
        end
    end

    always_comb begin
        bus_oe  = clr_n && !mul_busy && (ea || eu);
        bus_out = '0;
        if (bus_oe) bus_out = ea ? acc_q : alu_res;
    end

    assign bus_conflict = ea & eu;
    assign busy         = mul_busy;
    assign done         = mul_done;
    assign acc_out      = acc_q;
    assign acc_hi       = acc_hi_q;
    assign b_out        = b_q;
    assign flags        = flags_q;

endmodule

// File: tb/tb_sap_exec_unit.sv
// Self-checking bench for sap_exec_unit (WIDTH=8) against an arithmetic reference model.
module tb_sap_exec_unit;

    localparam int W  = 8;
    localparam int OP_MUL_I = 7;

    logic       clk = 1'b0;
    logic       clr_n, la_n, lb_n, ea, eu, start;
    logic [7:0] bus_in;
    logic [2:0] op;
    logic [7:0] bus_out, acc_out, acc_hi, b_out;
    logic [3:0] flags;
    logic       bus_oe, busy, done, bus_conflict;

    sap_exec_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .clr_n(clr_n), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .la_n(la_n), .lb_n(lb_n), .ea(ea), .eu(eu), .op(op), .start(start),
        .busy(busy), .done(done), .acc_out(acc_out), .acc_hi(acc_hi), .b_out(b_out),
        .flags(flags), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int         m_acc = 0, m_hi = 0, m_b = 0, m_left = 0, m_prod = 0;
    logic [3:0] m_flags = 4'b0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void alu_model(input int o, input int a, input int b,
                                      output int res, output logic [3:0] fl);
        int sa, sb;
        logic c, v;
        c = 1'b0; v = 1'b0; res = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (o)
            0: begin res = (a + b) % 256; c = (a + b) > 255; v = (sa + sb > 127) || (sa + sb < -128); end
            1: begin res = (a - b + 256) % 256; c = (a >= b); v = (sa - sb > 127) || (sa - sb < -128); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a * 2) % 256; c = (a >= 128); end
            6: begin res = a / 2; c = (a % 2 == 1); end
            default: res = 0;
        endcase
        fl = {c, v, (res >= 128), (res == 0)};
    endfunction

    task automatic mreset();
        m_acc = 0; m_hi = 0; m_b = 0; m_left = 0; m_flags = 4'b0000;
    endtask

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        int n_acc, n_hi, n_b, n_left, r;
        logic [3:0] n_flags, f;
        n_acc = m_acc; n_hi = m_hi; n_b = m_b; n_left = m_left; n_flags = m_flags;
        if (m_left > 0) begin
            n_left = m_left - 1;
            if (m_left == 2) begin
                n_acc   = m_prod % 256;
                n_hi    = m_prod / 256;
                n_flags = {(m_prod / 256) != 0, 1'b0, 1'b0, m_prod == 0};
            end
        end else begin
            if (!la_n) n_acc = bus_in;
            if (!lb_n) n_b = bus_in;
            alu_model(op, m_acc, m_b, r, f);
            if (eu && !ea && op != OP_MUL_I) n_flags = f;
            if (start && op == OP_MUL_I) begin
                n_left = W + 1;
                m_prod = m_acc * m_b;
            end
        end
        @(posedge clk);
        m_acc = n_acc; m_hi = n_hi; m_b = n_b; m_left = n_left; m_flags = n_flags;
        #1;
    endtask

    // Single compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        int r, eo;
        logic [3:0] f;
        logic oe;
        alu_model(op, m_acc, m_b, r, f);
        oe = clr_n && (m_left == 0) && (ea || eu);
        eo = !oe ? 0 : (ea ? m_acc : r);
        chk("acc_out", acc_out, m_acc);
        chk("acc_hi", acc_hi, m_hi);
        chk("b_out", b_out, m_b);
        chk("flags", flags, m_flags);
        chk("busy", busy, m_left > 0);
        chk("done", done, m_left == 1);
        chk("bus_oe", bus_oe, oe);
        chk("bus_out", bus_out, eo);
        chk("bus_conflict", bus_conflict, ea & eu);
    end

    task automatic load(input int a, input int b);
        bus_in = a[7:0]; la_n = 1'b0; tick(); la_n = 1'b1;
        bus_in = b[7:0]; lb_n = 1'b0; tick(); lb_n = 1'b1;
        bus_in = 8'($urandom);
    endtask

    task automatic alu_case(input string nm, input int o, input int a, input int b,
                            input int exp_res, input logic [3:0] exp_fl);
        load(a, b);
        op = o[2:0]; eu = 1'b1;
        #1;
        chk({nm, "_res"}, bus_out, exp_res);
        chk({nm, "_oe"}, bus_oe, 1);
        tick();
        chk({nm, "_flags"}, flags, exp_fl);
        eu = 1'b0;
    endtask

    task automatic mul_case(input string nm, input int a, input int b, input int exp_lo,
                            input int exp_hi, input logic [3:0] exp_fl, input bit disturb);
        int n, dpos;
        load(a, b);
        op = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; dpos = -1;
        while (busy === 1'b1 && n < 40) begin
            if (done === 1'b1) dpos = n;
            if (disturb) begin
                la_n = n[0]; lb_n = ~n[0]; ea = 1'b1; eu = n[1]; start = n[0];
                bus_in = 8'($urandom);
            end
            tick();
            n++;
        end
        la_n = 1'b1; lb_n = 1'b1; ea = 1'b0; eu = 1'b0; start = 1'b0;
        chk({nm, "_busy_cycles"}, n, 9);
        chk({nm, "_done_pos"}, dpos, 8);
        chk({nm, "_lo"}, acc_out, exp_lo);
        chk({nm, "_hi"}, acc_hi, exp_hi);
        chk({nm, "_flags"}, flags, exp_fl);
    endtask

    initial begin
        clr_n = 1'b0; la_n = 1'b1; lb_n = 1'b1; ea = 1'b0; eu = 1'b0;
        start = 1'b0; op = 3'd0; bus_in = 8'h00;
        mreset();
        #12 clr_n = 1'b1;
        #1 chk("reset_acc", acc_out, 0);
        chk("reset_flags", flags, 0);

        alu_case("add_ovf",  0, 'h7F, 'h01, 'h80, 4'b0110);
        alu_case("add_wrap", 0, 'hFF, 'h01, 'h00, 4'b1001);
        alu_case("sub_eq",   1, 'h05, 'h05, 'h00, 4'b1001);
        alu_case("sub_neg",  1, 'h03, 'h05, 'hFE, 4'b0010);
        alu_case("and",      2, 'hA5, 'h0F, 'h05, 4'b0000);
        alu_case("or",       3, 'hA5, 'h0F, 'hAF, 4'b0010);
        alu_case("xor",      4, 'hA5, 'h0F, 'hAA, 4'b0010);
        alu_case("shl",      5, 'h81, 'h00, 'h02, 4'b1000);
        alu_case("shr",      6, 'h81, 'h00, 'h40, 4'b1000);

        // ea and eu together: accumulator wins and flags stay at the SHR result.
        load('h33, 'h01);
        op = 3'd0; ea = 1'b1; eu = 1'b1;
        #1;
        chk("conflict_bus", bus_out, 'h33);
        chk("conflict_flag", bus_conflict, 1);
        tick();
        chk("conflict_flags_kept", flags, 4'b1000);
        ea = 1'b0; eu = 1'b0;

        mul_case("mul_0f_11", 'h0F, 'h11, 'hFF, 'h00, 4'b0000, 1'b0);
        mul_case("mul_ff_ff", 'hFF, 'hFF, 'h01, 'hFE, 4'b1000, 1'b0);
        mul_case("mul_disturb", 'h0F, 'h11, 'hFF, 'h00, 4'b0000, 1'b1);

        // Asynchronous reset in the middle of a multiply.
        load('h5A, 'h03);
        op = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("abort_busy_before", busy, 1);
        ea = 1'b1;
        #2 clr_n = 1'b0;
        mreset();
        #1;
        chk("abort_acc", acc_out, 0);
        chk("abort_hi", acc_hi, 0);
        chk("abort_b", b_out, 0);
        chk("abort_flags", flags, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_oe", bus_oe, 0);
        @(negedge clk);
        #2 clr_n = 1'b1; ea = 1'b0;
        tick(); tick();
        chk("abort_acc_after", acc_out, 0);

        for (int i = 0; i < 400; i++) begin
            la_n   = $urandom_range(0, 1);
            lb_n   = $urandom_range(0, 1);
            ea     = ($urandom_range(0, 3) == 0);
            eu     = $urandom_range(0, 1);
            op     = 3'($urandom_range(0, 7));
            start  = ($urandom_range(0, 5) == 0);
            bus_in = 8'($urandom);
            tick();
        end
        la_n = 1'b1; lb_n = 1'b1; ea = 1'b0; eu = 1'b0; start = 1'b0;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
